// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - multi-channel programmable phase-accumulator tick generator
//
// Purpose:
//   NCH independent channels, each with an ACC_W-bit phase accumulator that
//   adds a software-programmed increment every enabled cycle. The carry out of
//   the add produces either a one-cycle pulse or a toggle of a square wave, so
//   output rate = f_clk * inc / 2^ACC_W, exact on average.
//
// Ports:
//   clock  in   1              system clock, rising edge
//   reset  in   1              synchronous, active-high reset
//   wen    in   1              register write strobe
//   waddr  in   $clog2(NCH)+1  write address {channel, sel}; sel 0 = inc, 1 = ctrl
//   wdata  in   ACC_W          write data; ctrl uses bit0 = enable, bit1 = mode
//   raddr  in   $clog2(NCH)+1  readback address, same map as waddr
//   rdata  out  ACC_W          combinational readback (ctrl zero-extended)
//   tick   out  NCH            registered per-channel tick outputs

module tick_generator #(
  parameter int                    NCH      = 4,
  parameter int                    ACC_W    = 32,
  parameter logic [NCH*ACC_W-1:0]  DEF_INC  = '0,
  parameter logic [NCH*2-1:0]      DEF_CTRL = '0,
  localparam int                   AW       = $clog2(NCH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [ACC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ACC_W-1:0] rdata,
  output logic [NCH-1:0]   tick
);

  logic [ACC_W-1:0] acc  [NCH];
  logic [ACC_W-1:0] inc  [NCH];
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   mode;

  logic [ACC_W:0]   sum  [NCH];
  logic [NCH-1:0]   carry;
  logic [NCH-1:0]   wr_inc;
  logic [NCH-1:0]   wr_ctrl;

  logic [AW-1:0]    wch;
  logic [AW-1:0]    rch;

  // Channel field is everything above the sel bit; shifting keeps this
  // legal when NCH=1 and there are no channel bits at all.
  assign wch = waddr >> 1;
  assign rch = raddr >> 1;

  // Only channels 0..NCH-1 are decoded, so writes to higher indices fall
  // through without touching any state.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_inc[i]  = wen && !waddr[0] && (wch == AW'(i));
      wr_ctrl[i] = wen &&  waddr[0] && (wch == AW'(i));
      sum[i]     = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i]   = sum[i][ACC_W];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        acc[i]  <= '0;
        inc[i]  <= DEF_INC[i*ACC_W +: ACC_W];
        en[i]   <= DEF_CTRL[2*i];
        mode[i] <= DEF_CTRL[2*i+1];
        tick[i] <= 1'b0;
      end else if (wr_inc[i]) begin
        // New rate restarts the phase; any carry from this cycle is dropped.
        inc[i]  <= wdata;
        acc[i]  <= '0;
        tick[i] <= 1'b0;
      end else if (wr_ctrl[i]) begin
        // No add happens in a control-write cycle: the phase is kept, a
        // pulse-mode output returns low, a toggle output holds its level.
        en[i]   <= wdata[0];
        mode[i] <= wdata[1];
        if (wdata[1] != mode[i] || !wdata[1]) begin
          tick[i] <= 1'b0;
        end
      end else if (en[i]) begin
        acc[i]  <= sum[i][ACC_W-1:0];
        tick[i] <= mode[i] ? (tick[i] ^ carry[i]) : carry[i];
      end else if (!mode[i]) begin
        tick[i] <= 1'b0;
      end
    end
  end

  // Readback is taken from the registers directly, so a same-cycle write is
  // only visible after the edge.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rch == AW'(i)) begin
        rdata = raddr[0] ? ACC_W'({mode[i], en[i]}) : inc[i];
      end
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - directed self-checking bench for tick_generator

module tb_tick_generator;

  logic       clock;
  logic       reset;
  logic       wen;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] raddr;
  logic [7:0] rdata;
  logic [1:0] tick;

  int total;
  int bad;
  int clk_cnt;

  // channel 1 period tracking
  logic trk;
  int   last1;
  int   n1;
  int   gap_bad;

  tick_generator #(
    .NCH      (2),
    .ACC_W    (8),
    .DEF_INC  ({8'd0, 8'd64}),
    .DEF_CTRL ({2'b00, 2'b01})
  ) dut (
    .clock (clock),
    .reset (reset),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .tick  (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) clk_cnt++;

  always @(negedge clock) begin
    if (trk && tick[1]) begin
      if (last1 >= 0 && (clk_cnt - last1) != 4) gap_bad++;
      last1 = clk_cnt;
      n1++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    waddr = a;
    wdata = d;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
  endtask

  task automatic test_reset();
    int n0;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'd64; exp_rd[1] = 8'd1; exp_rd[2] = 8'd0; exp_rd[3] = 8'd0;
    reset = 1'b1;
    step();
    step();
    total++;
    if (tick !== 2'b00) begin
      bad++; $display("FAIL reset_tick got=%b exp=00", tick);
    end
    for (int a = 0; a < 4; a++) begin
      raddr = 2'(a);
      #1;
      total++;
      if (rdata !== exp_rd[a]) begin
        bad++; $display("FAIL reset_rdata addr=%0d got=%0d exp=%0d", a, rdata, exp_rd[a]);
      end
    end
    raddr = 2'd0;
    reset = 1'b0;
    n0 = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (tick[0]) n0++;
      total++;
      if (tick !== {1'b0, (k % 4) == 0}) begin
        bad++; $display("FAIL default_run cyc=%0d got=%b exp=%b", k, tick, {1'b0, (k % 4) == 0});
      end
    end
    total++;
    if (n0 !== 4) begin
      bad++; $display("FAIL default_count got=%0d exp=4", n0);
    end
  endtask

  task automatic test_fractional();
    int n0, last, mingap, maxgap;
    wr(2'd0, 8'd96);
    n0 = 0; last = -1; mingap = 999; maxgap = 0;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (tick[0]) begin
        n0++;
        if (last >= 0) begin
          if (k - last < mingap) mingap = k - last;
          if (k - last > maxgap) maxgap = k - last;
        end
        last = k;
      end
    end
    total++;
    if (n0 !== 96) begin
      bad++; $display("FAIL frac_count got=%0d exp=96", n0);
    end
    total++;
    if (mingap !== 2 || maxgap !== 3) begin
      bad++; $display("FAIL frac_spacing min=%0d max=%0d exp=2..3", mingap, maxgap);
    end
  endtask

  task automatic test_toggle();
    logic exp_t [6];
    logic exp_p [6];
    exp_t[0] = 0; exp_t[1] = 1; exp_t[2] = 1; exp_t[3] = 0; exp_t[4] = 0; exp_t[5] = 1;
    exp_p[0] = 0; exp_p[1] = 1; exp_p[2] = 0; exp_p[3] = 1; exp_p[4] = 0; exp_p[5] = 1;
    wr(2'd0, 8'd128);
    wr(2'd1, 8'd3);
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (tick[0] !== exp_t[k]) begin
        bad++; $display("FAIL toggle cyc=%0d got=%b exp=%b", k + 1, tick[0], exp_t[k]);
      end
    end
    wr(2'd1, 8'd1);
    total++;
    if (tick[0] !== 1'b0) begin
      bad++; $display("FAIL mode_change_clear got=%b exp=0", tick[0]);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (tick[0] !== exp_p[k]) begin
        bad++; $display("FAIL pulse_after_toggle cyc=%0d got=%b exp=%b", k + 1, tick[0], exp_p[k]);
      end
    end
  endtask

  task automatic test_collision();
    wr(2'd0, 8'd64);
    step(); step(); step();
    total++;
    if (dut.acc[0] !== 8'd192) begin
      bad++; $display("FAIL coll_setup acc got=%0d exp=192", dut.acc[0]);
    end
    wr(2'd0, 8'd32);
    total++;
    if (tick[0] !== 1'b0 || dut.acc[0] !== 8'd0) begin
      bad++; $display("FAIL coll_write tick=%b acc=%0d exp tick=0 acc=0", tick[0], dut.acc[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (tick[0] !== (k == 8)) begin
        bad++; $display("FAIL coll_next cyc=%0d got=%b exp=%b", k, tick[0], (k == 8));
      end
    end
  endtask

  task automatic test_disable_isolation();
    wr(2'd2, 8'd64);
    wr(2'd3, 8'd1);
    last1 = -1; n1 = 0; gap_bad = 0;
    trk = 1'b1;
    wr(2'd0, 8'd64);
    step(); step();
    total++;
    if (dut.acc[0] !== 8'd128) begin
      bad++; $display("FAIL dis_setup acc got=%0d exp=128", dut.acc[0]);
    end
    wr(2'd1, 8'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      total++;
      if (dut.acc[0] !== 8'd128 || tick[0] !== 1'b0) begin
        bad++; $display("FAIL dis_hold cyc=%0d acc=%0d tick=%b exp acc=128 tick=0", k, dut.acc[0], tick[0]);
      end
    end
    wr(2'd1, 8'd1);
    step();
    total++;
    if (tick[0] !== 1'b0 || dut.acc[0] !== 8'd192) begin
      bad++; $display("FAIL reen_first tick=%b acc=%0d exp tick=0 acc=192", tick[0], dut.acc[0]);
    end
    step();
    total++;
    if (tick[0] !== 1'b1) begin
      bad++; $display("FAIL reen_pulse got=%b exp=1", tick[0]);
    end
    for (int k = 0; k < 8; k++) step();
    trk = 1'b0;
    total++;
    if (gap_bad !== 0 || n1 !== 4) begin
      bad++; $display("FAIL ch1_isolation bad_gaps=%0d pulses=%0d exp 0 and 4", gap_bad, n1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'd64; exp_rd[1] = 8'd1; exp_rd[2] = 8'd0; exp_rd[3] = 8'd0;
    wr(2'd0, 8'd128);
    wr(2'd1, 8'd3);
    step(); step(); step();
    total++;
    if (tick[0] !== 1'b1 || dut.acc[0] !== 8'd128) begin
      bad++; $display("FAIL rmid_setup tick=%b acc=%0d exp tick=1 acc=128", tick[0], dut.acc[0]);
    end
    reset = 1'b1;
    waddr = 2'd0; wdata = 8'd200; wen = 1'b1;
    step();
    reset = 1'b0;
    wen = 1'b0;
    total++;
    if (tick !== 2'b00 || dut.acc[0] !== 8'd0 || dut.acc[1] !== 8'd0) begin
      bad++; $display("FAIL rmid_state tick=%b acc0=%0d acc1=%0d exp 00/0/0", tick, dut.acc[0], dut.acc[1]);
    end
    for (int a = 0; a < 4; a++) begin
      raddr = 2'(a);
      #1;
      total++;
      if (rdata !== exp_rd[a]) begin
        bad++; $display("FAIL rmid_rdata addr=%0d got=%0d exp=%0d", a, rdata, exp_rd[a]);
      end
    end
  endtask

  task automatic test_readback_max();
    int n0, n1c;
    raddr = 2'd2;
    waddr = 2'd2; wdata = 8'd255; wen = 1'b1;
    #1;
    total++;
    if (rdata !== 8'd0) begin
      bad++; $display("FAIL no_bypass got=%0d exp=0", rdata);
    end
    step();
    wen = 1'b0;
    total++;
    if (rdata !== 8'd255) begin
      bad++; $display("FAIL readback_new got=%0d exp=255", rdata);
    end
    wr(2'd3, 8'd1);
    raddr = 2'd0;
    #1;
    total++;
    if (rdata !== 8'd64) begin
      bad++; $display("FAIL ch0_inc_kept got=%0d exp=64", rdata);
    end
    n0 = 0; n1c = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (tick[0]) n0++;
      if (tick[1]) n1c++;
    end
    total++;
    if (n1c !== 255) begin
      bad++; $display("FAIL max_rate got=%0d exp=255", n1c);
    end
    total++;
    if (n0 !== 64) begin
      bad++; $display("FAIL ch0_quarter got=%0d exp=64", n0);
    end
  endtask

  initial begin
    total = 0; bad = 0; clk_cnt = 0;
    trk = 1'b0; last1 = -1; n1 = 0; gap_bad = 0;
    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    test_reset();
    test_fractional();
    test_toggle();
    test_collision();
    test_disable_isolation();
    test_reset_mid();
    test_readback_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
